// File: rtl/mont_pkg.sv
// Shared types and constants for the serial Montgomery multiplier.
// Imported by the interface, the datapath and the top.
package mont_pkg;

  localparam int DEFAULT_WIDTH = 2048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_SUB,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mont_mul_serial_if.sv
// Request/response bundle between a requester and mont_mul_serial.
// The requester drives start/a/b/n; the multiplier returns status and result.
interface mont_mul_serial_if
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] n;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (
    output start, a, b, n,
    input  busy, done, err, result
  );

  modport slave (
    input  start, a, b, n,
    output busy, done, err, result
  );

endinterface

// File: rtl/mont_final_sub.sv
// Final Montgomery reduction step: subtract n once if u >= n.
// Result is truncated to WIDTH bits.
module mont_final_sub
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH+1:0] u_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH+1:0] n_ext;
  logic [WIDTH-1:0] diff;

  assign n_ext = {2'b00, n_i};
  // Low WIDTH bits of u - n are all that survive truncation.
  assign diff  = u_i[WIDTH-1:0] - n_i;
  assign r_o   = (u_i >= n_ext) ? diff : u_i[WIDTH-1:0];

endmodule

// File: rtl/mont_mul_serial.sv
// Bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod n.
// One multiplier bit per cycle, fixed latency of WIDTH+2 cycles.
module mont_mul_serial
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst,
  mont_mul_serial_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH+1:0] u_q, u_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic [WIDTH+1:0] part;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] sub_r;

  mont_final_sub #(.WIDTH(WIDTH)) u_sub (
    .u_i (u_q),
    .n_i (n_q),
    .r_o (sub_r)
  );

  // b_q shifts right each MUL cycle, so b_q[0] is the current b_k.
  always_comb begin
    part = u_q + (b_q[0] ? {2'b00, a_q} : '0);
    sum  = part + (part[0] ? {2'b00, n_q} : '0);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    u_d     = u_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_MUL;
          a_d     = bus.a;
          b_d     = bus.b;
          n_d     = bus.n;
          u_d     = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_MUL: begin
        u_d = sum >> 1;
        b_d = b_q >> 1;
        if (cnt_q == LAST) begin
          state_d = ST_SUB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SUB: begin
        res_d   = n_q[0] ? sub_r : '0;
        err_d   = ~n_q[0];
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      u_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      u_q     <= u_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.err    = err_q;
  assign bus.result = res_q;

endmodule

// File: tb/tb_mont_mul_serial.sv
// Directed + random bench for mont_mul_serial (WIDTH=8 and WIDTH=64).
// Expected results queue up at launch and are popped on done.
module tb_mont_mul_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mont_mul_serial_if #(.WIDTH(8))  b8 ();
  mont_mul_serial_if #(.WIDTH(64)) b64 ();

  mont_mul_serial #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  mont_mul_serial #(.WIDTH(64)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ndone  = 0;

  logic [64:0] exp_q[$];
  logic [64:0] e;

  task automatic chk(input string tag,
                     input logic [64:0] obs,
                     input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pop_exp(output logic [64:0] v);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 65'd0, 65'd1);
      v = '0;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  // Ideal a*b*2^-64 mod n: reduce the product, then halve mod n 64 times.
  function automatic logic [63:0] ref64(input logic [63:0] a,
                                        input logic [63:0] b,
                                        input logic [63:0] n);
    logic [127:0] x;
    x = ({64'd0, a} * {64'd0, b}) % {64'd0, n};
    for (int i = 0; i < 64; i++) begin
      x = x[0] ? ((x + {64'd0, n}) >> 1) : (x >> 1);
    end
    return x[63:0];
  endfunction

  task automatic launch8(input logic [7:0] a,
                         input logic [7:0] b,
                         input logic [7:0] n,
                         input logic [7:0] er,
                         input logic       ee,
                         input logic       push);
    int guard;
    guard = 0;
    while (b8.busy && guard < 40) begin
      tick();
      guard++;
    end
    b8.a     = a;
    b8.b     = b;
    b8.n     = n;
    b8.start = 1'b1;
    if (push) exp_q.push_back({ee, 56'd0, er});
    cyc = 0;
    tick();
    b8.start = 1'b0;
    chk("busy_c1", {64'd0, b8.busy}, 65'd1);
  endtask

  task automatic finish8(input string tag, input int lat);
    while (!b8.done && cyc < 40) tick();
    chk({tag, "_done"}, {64'd0, b8.done}, 65'd1);
    chk({tag, "_lat"}, 65'(cyc), 65'(lat));
    pop_exp(e);
    chk({tag, "_res"}, {57'd0, b8.result}, {57'd0, e[7:0]});
    chk({tag, "_err"}, {64'd0, b8.err}, {64'd0, e[64]});
  endtask

  initial begin
    logic [63:0] ra, rb, rn;

    b8.start  = 1'b0;
    b8.a      = '0;
    b8.b      = '0;
    b8.n      = '0;
    b64.start = 1'b0;
    b64.a     = '0;
    b64.b     = '0;
    b64.n     = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", {64'd0, b8.busy}, 65'd0);
    chk("rst_done", {64'd0, b8.done}, 65'd0);
    chk("rst_err", {64'd0, b8.err}, 65'd0);
    chk("rst_res", {57'd0, b8.result}, 65'd0);
    chk("rst_res64", {1'b0, b64.result}, 65'd0);
    rst = 1'b0;
    tick();

    // Basic products, n=13
    launch8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0, 1'b1);
    finish8("m5x7", 10);
    launch8(8'd12, 8'd12, 8'd13, 8'd3, 1'b0, 1'b1);
    finish8("m12x12", 10);
    launch8(8'd0, 8'd9, 8'd13, 8'd0, 1'b0, 1'b1);
    finish8("m0x9", 10);
    launch8(8'd1, 8'd9, 8'd13, 8'd1, 1'b0, 1'b1);
    finish8("m1x9", 10);

    // Even modulus flags err, next valid request clears it
    launch8(8'd5, 8'd7, 8'd12, 8'd0, 1'b1, 1'b1);
    finish8("even_n", 10);
    launch8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0, 1'b1);
    chk("err_clr", {64'd0, b8.err}, 65'd0);
    finish8("after_err", 10);

    // Restart attempts while busy and in DONE are ignored
    launch8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0, 1'b1);
    ndone = 0;
    while (cyc < 3) begin
      if (b8.done) ndone++;
      tick();
    end
    b8.start = 1'b1;
    b8.a     = 8'd0;
    b8.b     = 8'd0;
    tick();
    b8.start = 1'b0;
    while (cyc < 10) begin
      if (b8.done) ndone++;
      tick();
    end
    if (b8.done) ndone++;
    chk("rs_done10", {64'd0, b8.done}, 65'd1);
    pop_exp(e);
    chk("rs_res", {57'd0, b8.result}, {57'd0, e[7:0]});
    b8.a     = 8'd12;
    b8.b     = 8'd12;
    b8.n     = 8'd13;
    b8.start = 1'b1;
    exp_q.push_back({1'b0, 56'd0, 8'd3});
    tick();
    chk("rs_idle11", {64'd0, b8.busy}, 65'd0);
    chk("rs_ndone", 65'(ndone), 65'd1);
    chk("rs_hold", {57'd0, b8.result}, 65'd1);
    tick();
    b8.start = 1'b0;
    chk("rs_busy12", {64'd0, b8.busy}, 65'd1);
    finish8("rs_next", 21);

    // Reset mid-operation aborts it
    launch8(8'd12, 8'd12, 8'd13, 8'd0, 1'b0, 1'b0);
    while (cyc < 5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_busy", {64'd0, b8.busy}, 65'd0);
    chk("ab_done", {64'd0, b8.done}, 65'd0);
    chk("ab_err", {64'd0, b8.err}, 65'd0);
    chk("ab_res", {57'd0, b8.result}, 65'd0);
    ndone = 0;
    repeat (15) begin
      if (b8.done) ndone++;
      tick();
    end
    chk("ab_nodone", 65'(ndone), 65'd0);

    // Reset wins over a simultaneous start
    b8.a     = 8'd5;
    b8.b     = 8'd7;
    b8.n     = 8'd13;
    b8.start = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    b8.start = 1'b0;
    chk("rst_prio", {64'd0, b8.busy}, 65'd0);
    tick();

    launch8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0, 1'b1);
    finish8("post_rst", 10);

    // WIDTH=64 random operands against the reference model
    for (int i = 0; i < 1000; i++) begin
      rn = {$urandom(), $urandom()} | 64'd1;
      if (rn == 64'd1) rn = 64'd3;
      ra = {$urandom(), $urandom()} % rn;
      rb = {$urandom(), $urandom()} % rn;
      exp_q.push_back({1'b0, ref64(ra, rb, rn)});
      b64.a     = ra;
      b64.b     = rb;
      b64.n     = rn;
      b64.start = 1'b1;
      cyc = 0;
      tick();
      b64.start = 1'b0;
      while (!b64.done && cyc < 80) tick();
      chk("r64_done", {64'd0, b64.done}, 65'd1);
      chk("r64_lat", 65'(cyc), 65'd66);
      pop_exp(e);
      chk("r64_res", {1'b0, b64.result}, {1'b0, e[63:0]});
      chk("r64_err", {64'd0, b64.err}, 65'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mont_mul_serial.md
MONT_MUL_SERIAL -- requirements
Module: mont_mul_serial

Interface
REQ-001 Parameter WIDTH, default 2048: operand/modulus width in bits, legal range 8..4096.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only while IDLE.
REQ-005 a  input  WIDTH  multiplicand, Montgomery domain, a < n.
REQ-006 b  input  WIDTH  multiplier, Montgomery domain, b < n.
REQ-007 n  input  WIDTH  modulus, odd, n > 1.
REQ-008 busy  output  1  high from the cycle after accepted start until done cycle inclusive.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 err  output  1  set with done when n was even or zero; cleared at next accepted start.
REQ-011 result  output  WIDTH  a*b*2^-WIDTH mod n; held stable until next accepted start.

Function
REQ-012 States IDLE, MUL, SUB, DONE; IDLE->MUL on start; MUL->SUB after WIDTH iterations; SUB->DONE; DONE->IDLE unconditionally.
REQ-013 On accepted start (cycle 0): register a, b, n; clear accumulator u (WIDTH+2 bits) and bit counter.
REQ-014 MUL cycle k (k=0..WIDTH-1): u <= (u + b_k*a + q*n) >> 1, q = (u + b_k*a)[0]; b_k is bit k of captured b, LSB first.
REQ-015 Bit counter width clog2(WIDTH)+1; exits MUL exactly when counter reaches WIDTH-1; no wrap.
REQ-016 SUB: result <= (u >= n) ? u - n : u, truncated to WIDTH bits.
REQ-017 Latency fixed: done high in cycle WIDTH+2 after the start-sampling cycle, independent of data.
REQ-018 start while busy ignored; inputs changing while busy have no effect (captured copies used).
REQ-019 start asserted in the DONE cycle ignored; start in the following IDLE cycle accepted (back-to-back throughput WIDTH+3 cycles).
REQ-020 Captured n even or zero: computation still runs full latency, result forced 0, err high with done.
REQ-021 Operands >= n: no check; result undefined but < 2n-bounded arithmetic must not overflow u.
REQ-022 No combinational path from any input to any output.

Reset
REQ-023 rst high at a clock edge: state IDLE, busy 0, done 0, err 0, result 0, u 0, counter 0.
REQ-024 rst mid-operation aborts it; no done is produced for the aborted request.
REQ-025 rst has priority over start in the same cycle.

Structure
REQ-026 Package mont_pkg holds state encoding enum and DEFAULT_WIDTH = 2048 constant.
REQ-027 One sub-module mont_final_sub: combinational compare-and-subtract (u, n) -> reduced value, parametrised by WIDTH.
REQ-028 No division, modulo or multiplication operators in RTL; adders/shifts only.

Verification (WIDTH=8, n=13, R^-1 mod 13 = 3)
REQ-029 a=5, b=7, start -> done at cycle 10, result=1, err=0.
REQ-030 a=12, b=12 -> result=3; a=0, b=9 -> result=0; a=1, b=9 -> result=1.
REQ-031 n=12, a=5, b=7 -> done at cycle 10, err=1, result=0; next valid request clears err.
REQ-032 start re-pulsed at cycles 3 and 10 of a running op -> single done, result unchanged; start at cycle 11 accepted.
REQ-033 rst at cycle 5 of an op -> no done, outputs zero; new op afterward returns correct result.
REQ-034 WIDTH=64 random odd n, a,b<n, 1000 ops -> result matches reference model a*b*2^-64 mod n.
